pht_update_queue: RTL and testbench

Buffers resolved conditional-branch outcomes from the integer issue lanes, computes saturated 2-bit counter updates, and drains them onto the pattern history table (PHT) write ports of the fetch-stage direction predictor. It also performs the post-reset PHT initialization sweep. With this block in place, bank conflicts are deferred instead of silently dropped, and the predictor's write ports are driven only from this queue. The block sits between the branch-resolution path (execute/writeback) and the predictor's multibank PHT RAM.

---
 rtl/pht_update_queue_pkg.sv | 26 ++
 rtl/pht_update_queue_counter_sat.sv | 21 ++
 rtl/pht_update_queue.sv | 175 +++++++++++++++++
 tb/tb_pht_update_queue.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pht_update_queue_pkg.sv
// Shared types and defaults for the PHT update queue: entry layout, FSM
// states, queue depth and the post-reset counter value.
package pht_update_queue_pkg;

  localparam int PHT_INDEX_WIDTH        = 12;
  localparam int PHT_COUNTER_WIDTH      = 2;
  localparam int PHT_UPDATE_QUEUE_DEPTH = 8;

  typedef struct packed {
    logic [PHT_INDEX_WIDTH-1:0]   index;
    logic [PHT_COUNTER_WIDTH-1:0] value;
  } PhtUpdateEntry;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pht_state_e;

  // Weakly-taken value: CTR_MAX/2 + 1.
  function automatic int pht_init_value(int ctr_w);
    return ((1 << ctr_w) - 1) / 2 + 1;
  endfunction

  localparam int PHT_INIT_VALUE = pht_init_value(PHT_COUNTER_WIDTH);

endpackage

// File: rtl/pht_update_queue_counter_sat.sv
// Combinational saturating up/down counter step for one branch lane.
module pht_counter_sat #(
  parameter int COUNTER_WIDTH = 2
) (
  input  logic [COUNTER_WIDTH-1:0] prev_i,
  input  logic                     taken_i,
  output logic [COUNTER_WIDTH-1:0] next_o
);

  localparam logic [COUNTER_WIDTH-1:0] CTR_MAX = '1;

  always_comb begin
    next_o = prev_i;
    if (taken_i) begin
      if (prev_i != CTR_MAX) next_o = prev_i + COUNTER_WIDTH'(1);
    end else begin
      if (prev_i != '0) next_o = prev_i - COUNTER_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pht_update_queue.sv
// PHT update queue: post-reset init sweep, then buffers branch outcomes and drains
// them onto the PHT write ports. Optional dropCount via PHT_UPDATE_QUEUE_STATS_EN.
module pht_update_queue
  import pht_update_queue_pkg::*;
#(
  parameter  int ENTRY_NUM     = 4096,
  parameter  int ISSUE_WIDTH   = 2,
  parameter  int COUNTER_WIDTH = 2,
  parameter  int BANK_NUM      = 2,
  parameter  int QUEUE_DEPTH   = PHT_UPDATE_QUEUE_DEPTH,
  localparam int INDEX_WIDTH   = $clog2(ENTRY_NUM),
  localparam int CNT_W         = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [ISSUE_WIDTH-1:0]                    brValid,
  input  logic [ISSUE_WIDTH-1:0][INDEX_WIDTH-1:0]   brIndex,
  input  logic [ISSUE_WIDTH-1:0][COUNTER_WIDTH-1:0] brPrevCounter,
  input  logic [ISSUE_WIDTH-1:0]                    brTaken,
  output logic [ISSUE_WIDTH-1:0]                    phtWE,
  output logic [ISSUE_WIDTH-1:0][INDEX_WIDTH-1:0]   phtWA,
  output logic [ISSUE_WIDTH-1:0][COUNTER_WIDTH-1:0] phtWV,
  output logic                                      initDone,
  output logic [CNT_W-1:0]                          queueCount
`ifdef PHT_UPDATE_QUEUE_STATS_EN
  ,
  output logic [15:0]                               dropCount
`endif
);

  localparam int PTR_W = CNT_W - 1;
  localparam int P1    = (ISSUE_WIDTH > 1) ? 1 : 0;
  localparam logic [INDEX_WIDTH-1:0]   BANK_MASK = INDEX_WIDTH'(BANK_NUM - 1);
  localparam logic [INDEX_WIDTH-1:0]   LAST_IDX  = INDEX_WIDTH'(ENTRY_NUM - 1);
  localparam logic [COUNTER_WIDTH-1:0] INIT_VAL  = COUNTER_WIDTH'(pht_init_value(COUNTER_WIDTH));

  typedef struct packed {
    logic [INDEX_WIDTH-1:0]   index;
    logic [COUNTER_WIDTH-1:0] value;
  } entry_t;

  pht_state_e             state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_idx_q, sweep_idx_d;
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d, head1;
  logic [CNT_W-1:0]       count_q, count_d, enq, deq, free;
  entry_t                 mem_q [QUEUE_DEPTH];
  logic                   keep;

  logic [ISSUE_WIDTH-1:0]                    wr_en;
  logic [ISSUE_WIDTH-1:0][PTR_W-1:0]         wr_ptr;
  logic [ISSUE_WIDTH-1:0][COUNTER_WIDTH-1:0] new_ctr;
`ifdef PHT_UPDATE_QUEUE_STATS_EN
  logic [15:0] drop_num;
`endif

  for (genvar l = 0; l < ISSUE_WIDTH; l++) begin : g_lane
    pht_counter_sat #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_sat (
      .prev_i  (brPrevCounter[l]),
      .taken_i (brTaken[l]),
      .next_o  (new_ctr[l])
    );
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    phtWE       = '0;
    phtWA       = '0;
    phtWV       = '0;
    wr_en       = '0;
    wr_ptr      = '0;
    enq         = '0;
    deq         = '0;
    free        = '0;
    keep        = 1'b0;
    head1       = head_q + PTR_W'(1);
`ifdef PHT_UPDATE_QUEUE_STATS_EN
    drop_num    = '0;
`endif
    unique case (state_q)
      ST_INIT: begin
        phtWE[0]    = 1'b1;
        phtWA[0]    = sweep_idx_q;
        phtWV[0]    = INIT_VAL;
        sweep_idx_d = sweep_idx_q + INDEX_WIDTH'(1);
        if (sweep_idx_q == LAST_IDX) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (count_q != '0) begin
          phtWE[0] = 1'b1;
          phtWA[0] = mem_q[head_q].index;
          phtWV[0] = mem_q[head_q].value;
          deq      = CNT_W'(1);
        end
        // Second port only when the two oldest entries live in different banks.
        if (ISSUE_WIDTH > 1 && count_q >= CNT_W'(2) &&
            ((mem_q[head1].index & BANK_MASK) != (mem_q[head_q].index & BANK_MASK))) begin
          phtWE[P1] = 1'b1;
          phtWA[P1] = mem_q[head1].index;
          phtWV[P1] = mem_q[head1].value;
          deq       = CNT_W'(2);
        end
        free = CNT_W'(QUEUE_DEPTH) - count_q + deq;
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
          keep = brValid[l];
          for (int k = 0; k < l; k++) begin
            if (brValid[k] && brIndex[k] == brIndex[l]) keep = 1'b0;
          end
          if (keep) begin
            if (enq < free) begin
              wr_en[l]  = 1'b1;
              wr_ptr[l] = tail_q + PTR_W'(enq);
              enq       = enq + CNT_W'(1);
            end
`ifdef PHT_UPDATE_QUEUE_STATS_EN
            else begin
              drop_num = drop_num + 16'd1;
            end
`endif
          end
        end
        head_d  = head_q + PTR_W'(deq);
        tail_d  = tail_q + PTR_W'(enq);
        count_d = count_q + enq - deq;
      end
    endcase
    if (rst) phtWE = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      sweep_idx_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      if (wr_en[l]) mem_q[wr_ptr[l]] <= '{index: brIndex[l], value: new_ctr[l]};
    end
  end

  assign initDone   = (state_q == ST_RUN);
  assign queueCount = count_q;

`ifdef PHT_UPDATE_QUEUE_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + {1'b0, drop_num};
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign dropCount = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pht_update_queue.sv
// Randomized bench for pht_update_queue against a queue-based reference model.
module tb_pht_update_queue;
  localparam int EN = 16, IW = 2, CW = 2, BN = 2, QD = 8, XW = 4, CNTW = 4;
  localparam int CMAX = 3, INITV = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [IW-1:0]           brValid, brTaken, phtWE;
  logic [IW-1:0][XW-1:0]   brIndex, phtWA;
  logic [IW-1:0][CW-1:0]   brPrevCounter, phtWV;
  logic                    initDone;
  logic [CNTW-1:0]         queueCount;
`ifdef PHT_UPDATE_QUEUE_STATS_EN
  logic [15:0]             dropCount;
`endif

  pht_update_queue #(
    .ENTRY_NUM(EN), .ISSUE_WIDTH(IW), .COUNTER_WIDTH(CW), .BANK_NUM(BN), .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk), .rst(rst), .brValid(brValid), .brIndex(brIndex),
    .brPrevCounter(brPrevCounter), .brTaken(brTaken),
    .phtWE(phtWE), .phtWA(phtWA), .phtWV(phtWV),
    .initDone(initDone), .queueCount(queueCount)
`ifdef PHT_UPDATE_QUEUE_STATS_EN
    , .dropCount(dropCount)
`endif
  );

  typedef struct { int idx; int val; } ent_t;
  ent_t mq[$];
  bit   m_init;
  int   m_sweep, m_drops;
  int   n_vec, n_err;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int upd(int p, bit t);
    if (t) return (p + 1 > CMAX) ? CMAX : p + 1;
    return (p - 1 < 0) ? 0 : p - 1;
  endfunction

  task automatic drive(bit v0, int i0, int p0, bit t0, bit v1, int i1, int p1, bit t1);
    brValid[0] = v0; brIndex[0] = XW'(i0); brPrevCounter[0] = CW'(p0); brTaken[0] = t0;
    brValid[1] = v1; brIndex[1] = XW'(i1); brPrevCounter[1] = CW'(p1); brTaken[1] = t1;
  endtask

  task automatic drive_rand(bit bank0);
    int i0, i1;
    i0 = $urandom_range(0, EN - 1);
    i1 = $urandom_range(0, EN - 1);
    if (bank0) begin i0 = i0 & ~1; i1 = i1 & ~1; end
    drive($urandom_range(0, 3) != 0, i0, $urandom_range(0, CMAX), $urandom_range(0, 1) != 0,
          $urandom_range(0, 3) != 0, i1, $urandom_range(0, CMAX), $urandom_range(0, 1) != 0);
  endtask

  task automatic cycle();
    int we, ndeq;
    we = 0; ndeq = 0;
    @(negedge clk);
    if (rst) begin
      we = 0;
    end else if (m_init) begin
      we = 1;
      check_val("sweep_wa0", 32'(phtWA[0]), 32'(m_sweep));
      check_val("sweep_wv0", 32'(phtWV[0]), 32'(INITV));
    end else if (mq.size() >= 1) begin
      we = 1; ndeq = 1;
      check_val("wa0", 32'(phtWA[0]), 32'(mq[0].idx));
      check_val("wv0", 32'(phtWV[0]), 32'(mq[0].val));
      if (mq.size() >= 2 && (mq[1].idx % BN) != (mq[0].idx % BN)) begin
        we = 3; ndeq = 2;
        check_val("wa1", 32'(phtWA[1]), 32'(mq[1].idx));
        check_val("wv1", 32'(phtWV[1]), 32'(mq[1].val));
      end
    end
    check_val("we", 32'(phtWE), 32'(we));
    check_val("initDone", 32'(initDone), 32'(!m_init));
    check_val("queueCount", 32'(queueCount), 32'(mq.size()));
`ifdef PHT_UPDATE_QUEUE_STATS_EN
    check_val("dropCount", 32'(dropCount), 32'(m_drops));
`endif
    if (rst) begin
      m_init = 1'b1; m_sweep = 0; m_drops = 0; mq.delete();
    end else if (m_init) begin
      if (m_sweep == EN - 1) m_init = 1'b0;
      m_sweep = (m_sweep + 1) % EN;
    end else begin
      repeat (ndeq) void'(mq.pop_front());
      for (int l = 0; l < IW; l++) begin
        if (!brValid[l]) continue;
        if (l == 1 && brValid[0] && brIndex[0] == brIndex[1]) continue;
        if (mq.size() < QD) mq.push_back('{int'(brIndex[l]), upd(int'(brPrevCounter[l]), brTaken[l])});
        else if (m_drops < 16'hFFFF) m_drops++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) cycle();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    m_init = 1'b1; m_sweep = 0; m_drops = 0;
    @(posedge clk); #1;
    repeat (2) cycle();
    rst = 1'b0;

    // Init sweep with live but ignored branch inputs
    for (int c = 0; c < EN; c++) begin drive_rand(1'b0); cycle(); end
    idle(2);

    // Saturation, different banks
    drive(1, 5, 3, 1, 1, 8, 0, 0); cycle();
    idle(3);
    // Bank conflict
    drive(1, 4, 1, 1, 1, 6, 1, 1); cycle();
    idle(3);
    // Same index on both lanes
    drive(1, 7, 1, 0, 1, 7, 2, 1); cycle();
    idle(2);

    // Fill with bank-0 pairs until full and dropping
    for (int c = 0; c < 12; c++) begin drive_rand(1'b1); brValid = 2'b11; cycle(); end
    idle(10);

    // Reset mid-drain
    for (int c = 0; c < 5; c++) begin drive_rand(1'b1); brValid = 2'b11; cycle(); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; cycle();
    rst = 1'b0;
    idle(EN + 2);

    // Random traffic with occasional reset
    for (int c = 0; c < 600; c++) begin
      drive_rand($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    idle(EN + 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
